// File: rtl/uart_loader.sv
// Boot loader: length-prefixed LE word stream from UART into instruction memory, then ack byte and core release.
// One-cycle registered write strobe per word; ack byte held on tx_valid until tx_ready, rx ignored after load.
module uart_loader #(
  parameter int          ADDR_W   = 15,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {HDR, DATA, ACK, RUN} state_t;

  // One past the last word address; 33 bits so the compare never truncates.
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

  state_t      state;
  logic [31:0] n;
  logic [31:0] w;
  logic [31:0] word;
  logic [1:0]  idx;
  logic [31:0] n_full;
  logic [31:0] word_full;

  // Header/word value including the byte arriving this cycle.
  always_comb begin
    n_full    = n;
    word_full = word;
    n_full[{idx, 3'b000} +: 8]    = rx_data;
    word_full[{idx, 3'b000} +: 8] = rx_data;
  end

  assign done = cpu_rstn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= HDR;
      n         <= '0;
      w         <= '0;
      word      <= '0;
      idx       <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rstn  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR: begin
          if (rx_valid) begin
            n   <= n_full;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              if ({1'b0, n_full} > DEPTH) overflow <= 1'b1;
              if (n_full == 32'd0) begin
                state    <= ACK;
                tx_valid <= 1'b1;
                tx_data  <= ACK_BYTE;
              end else begin
                state <= DATA;
                w     <= '0;
              end
            end
          end
        end
        DATA: begin
          // w only equals n here during the final write cycle.
          if (w == n) begin
            state    <= ACK;
            tx_valid <= 1'b1;
            tx_data  <= ACK_BYTE;
          end else if (rx_valid) begin
            word <= word_full;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              mem_we    <= ({1'b0, w} < DEPTH);
              mem_addr  <= w[ADDR_W-1:0];
              mem_wdata <= word_full;
              w         <= w + 32'd1;
            end
          end
        end
        ACK: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            cpu_rstn <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: ;
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: default depth and a 4-word instance driven by the same stimulus.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;

  logic        tx_valid1, mem_we1, cpu_rstn1, done1, ovf1;
  logic [7:0]  tx_data1;
  logic [14:0] mem_addr1;
  logic [31:0] mem_wdata1;

  logic        tx_valid2, mem_we2, cpu_rstn2, done2, ovf2;
  logic [7:0]  tx_data2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp1[$];
  logic [63:0] exp2[$];
  logic [7:0]  data_q[$];
  logic [63:0] e1, e2;

  always #5 clk = ~clk;

  uart_loader dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .cpu_rstn(cpu_rstn1), .done(done1), .overflow(ovf1)
  );

  uart_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid2), .tx_data(tx_data2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .cpu_rstn(cpu_rstn2), .done(done2), .overflow(ovf2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitors: every strobe must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (mem_we1) begin
      if (exp1.size() == 0) check("wr1_unexpected", 64'd1, 64'd0);
      else begin
        e1 = exp1.pop_front();
        check("wr1_addr", 64'(mem_addr1), 64'(e1[63:32]));
        check("wr1_data", 64'(mem_wdata1), 64'(e1[31:0]));
      end
    end
    if (mem_we2) begin
      if (exp2.size() == 0) check("wr2_unexpected", 64'd1, 64'd0);
      else begin
        e2 = exp2.pop_front();
        check("wr2_addr", 64'(mem_addr2), 64'(e2[63:32]));
        check("wr2_data", 64'(mem_wdata2), 64'(e2[31:0]));
      end
    end
  end

  task automatic do_reset();
    rstn     = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    #1;
    check("rst_outs1", 64'({tx_valid1, tx_data1, mem_we1, mem_addr1, mem_wdata1, cpu_rstn1, done1, ovf1}), 64'd0);
    check("rst_outs2", 64'({tx_valid2, tx_data2, mem_we2, mem_addr2, mem_wdata2, cpu_rstn2, done2, ovf2}), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic fill(input int words, input logic [7:0] start);
    for (int k = 0; k < 4 * words; k++) data_q.push_back(8'(start + k));
  endtask

  // Called in the first cycle tx_valid should be high; holds tx_ready low for 'hold' edges.
  task automatic ack_phase(input int hold);
    tx_ready = (hold == 0);
    check("ack_on", 64'({tx_valid1, tx_data1, cpu_rstn1, tx_valid2, tx_data2, cpu_rstn2}),
          64'({1'b1, 8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("ack_hold", 64'({tx_valid1, tx_data1, cpu_rstn1, tx_valid2, tx_data2, cpu_rstn2}),
            64'({1'b1, 8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0}));
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("released", 64'({tx_valid1, cpu_rstn1, done1, tx_valid2, cpu_rstn2, done2}), 64'b011011);
    tx_ready = 1'b0;
  endtask

  task automatic run_load(input int n, input bit b2b, input int hold);
    logic [31:0] nn;
    logic [31:0] wd;
    nn = 32'(n);
    for (int j = 0; j < 4; j++) send(nn[8*j +: 8], !b2b);
    check("ovf1", 64'(ovf1), 64'(n > 32768));
    check("ovf2", 64'(ovf2), 64'(n > 4));
    for (int w = 0; w < n; w++) begin
      wd = {data_q[3], data_q[2], data_q[1], data_q[0]};
      exp1.push_back({32'(w), wd});
      if (w < 4) exp2.push_back({32'(w), wd});
      for (int j = 0; j < 4; j++) send(data_q.pop_front(), !b2b);
    end
    if (n > 0) begin
      @(posedge clk); #1;
    end
    ack_phase(hold);
    check("q1_drained", 64'(exp1.size()), 64'd0);
    check("q2_drained", 64'(exp2.size()), 64'd0);
  endtask

  task automatic run_mode_traffic();
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
      check("run_stable", 64'({tx_valid1, cpu_rstn1, tx_valid2, cpu_rstn2}), 64'b0101);
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    rstn     = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    @(posedge clk); #1;

    do_reset();
    data_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_load(1, 1'b0, 0);

    do_reset();
    fill(3, 8'h01);
    run_load(3, 1'b1, 0);

    do_reset();
    run_load(0, 1'b1, 10);

    do_reset();
    fill(5, 8'h20);
    run_load(5, 1'b1, 0);

    do_reset();
    fill(4, 8'h40);
    run_load(4, 1'b1, 0);

    // Reset partway through the second word of a two-word load.
    do_reset();
    for (int j = 0; j < 4; j++) send(j == 0 ? 8'h02 : 8'h00, 1'b0);
    fill(2, 8'h60);
    exp1.push_back({32'd0, 32'h63626160});
    exp2.push_back({32'd0, 32'h63626160});
    for (int k = 0; k < 6; k++) send(data_q.pop_front(), 1'b0);
    data_q.delete();
    do_reset();
    check("mid_q1", 64'(exp1.size()), 64'd0);
    check("mid_q2", 64'(exp2.size()), 64'd0);
    data_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(1, 1'b1, 0);
    run_mode_traffic();
    repeat (2) @(posedge clk);
    #1;
    check("run_no_wr", 64'(exp1.size() + exp2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
